// File: rtl/page_bitmap_alloc_pkg.sv
// Shared sizes and FSM encoding for the MMU page allocator and its settle timer.
// Latency: n/a (types only); backpressure: n/a.
package mmu_alloc_pkg;

    localparam int NUM_PAGES = 64;
    localparam int PAGE_W    = 6;
    localparam int POS_W     = 7;

    typedef enum logic {
        SETTLE = 1'b0,
        READY  = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/page_bitmap_alloc_if.sv
// Alloc request/response and page release handshake between front-end (master) and allocator (slave).
// Latency: response one cycle after an alloc handshake; backpressure: alloc_ready only, frees always accepted.
interface page_bitmap_alloc_if;

    logic                            alloc_valid;
    logic                            alloc_ready;
    logic                            alloc_resp_valid;
    logic                            alloc_resp_ok;
    logic [mmu_alloc_pkg::PAGE_W-1:0] alloc_resp_page;
    logic                            free_valid;
    logic [mmu_alloc_pkg::PAGE_W-1:0] free_page;
    logic                            free_ready;
    logic                            free_err;

    modport master (
        output alloc_valid, free_valid, free_page,
        input  alloc_ready, alloc_resp_valid, alloc_resp_ok, alloc_resp_page,
        input  free_ready, free_err
    );

    modport slave (
        input  alloc_valid, free_valid, free_page,
        output alloc_ready, alloc_resp_valid, alloc_resp_ok, alloc_resp_page,
        output free_ready, free_err
    );

endinterface

// File: rtl/page_bitmap_alloc_settle_timer.sv
// Loadable FZ_LAT down-counter; 'last' marks the cycle whose edge lets the finder result be trusted.
// Latency: FZ_LAT cycles from load to counter reaching zero; backpressure: none.
module alloc_settle_timer #(
    parameter int FZ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    localparam int CNT_W = (FZ_LAT < 2) ? 1 : $clog2(FZ_LAT + 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= CNT_W'(FZ_LAT);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The FSM leaves SETTLE on the same edge that takes the counter to zero.
    assign last = (cnt <= CNT_W'(1));

endmodule

// File: rtl/page_bitmap_alloc.sv
// Owns the 64-page allocation bitmap: feeds the external first-zero finder and grants allocs from its result.
// Latency: alloc/free responses one cycle after handshake; backpressure: alloc_ready low for FZ_LAT cycles after any bitmap change, frees never stalled.
module page_bitmap_alloc
    import mmu_alloc_pkg::*;
#(
    parameter int FZ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    page_bitmap_alloc_if.slave   req,
    output logic [NUM_PAGES-1:0] fz_data_out,
    input  logic                 fz_find_success,
    input  logic [POS_W-1:0]     fz_pos,
    input  logic [NUM_PAGES-1:0] fz_mask,
    output logic [POS_W-1:0]     free_count,
    output logic                 full
);

    logic [NUM_PAGES-1:0] bitmap;
    logic [NUM_PAGES-1:0] bitmap_next;
    logic [NUM_PAGES-1:0] set_mask;
    logic [NUM_PAGES-1:0] clr_mask;
    logic [POS_W-1:0]     count_next;
    alloc_state_t         state;
    logic                 ready_q;
    logic                 resp_vld_q;
    logic                 resp_ok_q;
    logic [PAGE_W-1:0]    resp_page_q;
    logic                 free_err_q;
    logic                 alloc_fire;
    logic                 alloc_ok;
    logic                 free_hit;
    logic                 free_miss;
    logic                 bitmap_chg;
    logic                 settle_last;
    logic                 unused_pos_msb;

    assign unused_pos_msb = fz_pos[POS_W-1];

    assign alloc_fire = req.alloc_valid & ready_q;
    assign alloc_ok   = alloc_fire & fz_find_success;
    // Free check looks only at the registered bitmap, so freeing the page granted this cycle is a double free.
    assign free_hit   = req.free_valid &  bitmap[req.free_page];
    assign free_miss  = req.free_valid & ~bitmap[req.free_page];

    assign set_mask    = alloc_ok ? fz_mask : '0;
    assign clr_mask    = free_hit ? (NUM_PAGES'(1) << req.free_page) : '0;
    assign bitmap_next = (bitmap | set_mask) & ~clr_mask;
    assign bitmap_chg  = alloc_ok | free_hit;

    always_comb begin
        count_next = free_count;
        case ({free_hit, alloc_ok})
            2'b10:   count_next = free_count + POS_W'(1);
            2'b01:   count_next = free_count - POS_W'(1);
            default: count_next = free_count;
        endcase
    end

    alloc_settle_timer #(
        .FZ_LAT (FZ_LAT)
    ) u_settle (
        .clk  (clk),
        .rst  (rst),
        .load (bitmap_chg),
        .last (settle_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            free_count  <= POS_W'(NUM_PAGES);
            full        <= 1'b0;
            state       <= SETTLE;
            ready_q     <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_ok_q   <= 1'b0;
            resp_page_q <= '0;
            free_err_q  <= 1'b0;
        end else begin
            bitmap      <= bitmap_next;
            free_count  <= count_next;
            full        <= (count_next == '0);
            resp_vld_q  <= alloc_fire;
            resp_ok_q   <= alloc_ok;
            resp_page_q <= alloc_ok ? fz_pos[PAGE_W-1:0] : '0;
            free_err_q  <= free_miss;
            if (bitmap_chg) begin
                state   <= SETTLE;
                ready_q <= 1'b0;
            end else begin
                case (state)
                    SETTLE: begin
                        if (settle_last) begin
                            state   <= READY;
                            ready_q <= 1'b1;
                        end
                    end
                    READY: begin
                        state   <= READY;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state   <= SETTLE;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fz_data_out          = bitmap;
    assign req.alloc_ready      = ready_q;
    assign req.alloc_resp_valid = resp_vld_q;
    assign req.alloc_resp_ok    = resp_ok_q;
    assign req.alloc_resp_page  = resp_page_q;
    assign req.free_ready       = 1'b1;
    assign req.free_err         = free_err_q;

endmodule

// File: tb/tb_page_bitmap_alloc.sv
// Bench for page_bitmap_alloc: two instances (finder latency 1 and 2) exercised in turn against a page-set model.
module tb_page_bitmap_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         run = 0;
    int         lat = 1;
    logic       alloc_valid = 1'b0;
    logic       free_valid  = 1'b0;
    logic [5:0] free_page   = 6'd0;
    int         errors = 0;
    int         checks = 0;
    bit         used [64];

    always #5 clk = ~clk;

    page_bitmap_alloc_if if1 ();
    page_bitmap_alloc_if if2 ();

    assign if1.alloc_valid = (run == 0) && alloc_valid;
    assign if1.free_valid  = (run == 0) && free_valid;
    assign if1.free_page   = free_page;
    assign if2.alloc_valid = (run == 1) && alloc_valid;
    assign if2.free_valid  = (run == 1) && free_valid;
    assign if2.free_page   = free_page;

    logic [63:0] d1, d2, m1, m2;
    logic [6:0]  p1, p2, c1, c2;
    logic        s1, s2, fl1, fl2;

    page_bitmap_alloc #(.FZ_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .req(if1), .fz_data_out(d1), .fz_find_success(s1),
        .fz_pos(p1), .fz_mask(m1), .free_count(c1), .full(fl1)
    );

    page_bitmap_alloc #(.FZ_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .req(if2), .fz_data_out(d2), .fz_find_success(s2),
        .fz_pos(p2), .fz_mask(m2), .free_count(c2), .full(fl2)
    );

    // Finder model: lowest-zero search behind one (dut1) or two (dut2) register stages.
    function automatic logic [6:0] lowest_zero(input logic [63:0] d);
        logic [6:0] r = 7'd64;
        for (int i = 63; i >= 0; i--) if (!d[i]) r = 7'(i);
        return r;
    endfunction

    logic [63:0] q1 = '1, q2a = '1, q2b = '1;
    always @(posedge clk) begin
        q1  <= d1;
        q2a <= d2;
        q2b <= q2a;
    end
    assign p1 = lowest_zero(q1);
    assign s1 = !p1[6];
    assign m1 = s1 ? (64'd1 << p1[5:0]) : 64'd0;
    assign p2 = lowest_zero(q2b);
    assign s2 = !p2[6];
    assign m2 = s2 ? (64'd1 << p2[5:0]) : 64'd0;

    always @(negedge clk) begin
        if (s1) assert (m1 == (64'd1 << p1[5:0]));
        if (s2) assert (m2 == (64'd1 << p2[5:0]));
    end

    logic        o_ready, o_rv, o_ok, o_fe, o_frdy, o_full;
    logic [5:0]  o_pg;
    logic [63:0] o_data;
    logic [6:0]  o_cnt;
    always_comb begin
        if (run == 1) begin
            o_ready = if2.alloc_ready; o_rv = if2.alloc_resp_valid; o_ok = if2.alloc_resp_ok;
            o_pg = if2.alloc_resp_page; o_fe = if2.free_err; o_frdy = if2.free_ready;
            o_data = d2; o_cnt = c2; o_full = fl2;
        end else begin
            o_ready = if1.alloc_ready; o_rv = if1.alloc_resp_valid; o_ok = if1.alloc_resp_ok;
            o_pg = if1.alloc_resp_page; o_fe = if1.free_err; o_frdy = if1.free_ready;
            o_data = d1; o_cnt = c1; o_full = fl1;
        end
    end

    function automatic int model_free_cnt();
        int n = 0;
        for (int i = 0; i < 64; i++) if (!used[i]) n++;
        return n;
    endfunction

    function automatic int model_lowest();
        for (int i = 0; i < 64; i++) if (!used[i]) return i;
        return -1;
    endfunction

    function automatic logic [63:0] model_bits();
        logic [63:0] b = '0;
        for (int i = 0; i < 64; i++) b[i] = used[i];
        return b;
    endfunction

    // Free checks the page set before this cycle's grant; a grant takes the lowest free page.
    task automatic model_step(input bit do_alloc, input bit do_free, input logic [5:0] fp,
                              output bit e_ok, output logic [5:0] e_pg, output bit e_err);
        int lo;
        lo    = model_lowest();
        e_ok  = do_alloc && (lo >= 0);
        e_pg  = e_ok ? 6'(lo) : 6'd0;
        e_err = do_free && !used[fp];
        if (e_ok) used[lo] = 1'b1;
        if (do_free && !e_err) used[fp] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; alloc_valid = 1'b0; free_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (o_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: alloc_ready=%b want 1", tag, o_ready);
        end
    endtask

    task automatic alloc_op(input bit do_free, input logic [5:0] fp,
                            output logic rv, output logic ok, output logic [5:0] pg, output logic fe);
        alloc_valid = 1'b1; free_valid = do_free; free_page = fp;
        tick();
        alloc_valid = 1'b0; free_valid = 1'b0;
        rv = o_rv; ok = o_ok; pg = o_pg; fe = o_fe;
    endtask

    task automatic test_reset();
        logic rv, ok, fe; logic [5:0] pg; bit e_ok, e_err; logic [5:0] e_pg;
        do_reset();
        checks++;
        if ({o_rv, o_ok, o_pg, o_fe, o_full, o_data} !== '0) begin
            errors++; $display("FAIL reset_outputs: rv=%b ok=%b pg=%0d fe=%b full=%b data=%h want all 0", o_rv, o_ok, o_pg, o_fe, o_full, o_data);
        end
        checks++;
        if (o_cnt !== 7'd64 || o_frdy !== 1'b1) begin
            errors++; $display("FAIL reset_count: free_count=%0d free_ready=%b want 64/1", o_cnt, o_frdy);
        end
        for (int k = 0; k < lat; k++) begin
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_settle c%0d: alloc_ready=%b want 0", k, o_ready); end
            tick();
        end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: alloc_ready=%b want 1", o_ready); end
        alloc_op(1'b0, 6'd0, rv, ok, pg, fe);
        model_step(1'b1, 1'b0, 6'd0, e_ok, e_pg, e_err);
        checks++;
        if ({rv, ok, pg} !== {1'b1, e_ok, e_pg} || e_pg !== 6'd0) begin
            errors++; $display("FAIL first_alloc: rv=%b ok=%b page=%0d want 1/1/0", rv, ok, pg);
        end
        checks++;
        if (o_data !== 64'h1 || o_cnt !== 7'd63) begin
            errors++; $display("FAIL first_alloc_state: data=%h count=%0d want 1/63", o_data, o_cnt);
        end
        for (int k = 0; k < lat; k++) begin
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL alloc_settle c%0d: alloc_ready=%b want 0", k, o_ready); end
            tick();
        end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL alloc_reready: alloc_ready=%b want 1", o_ready); end
    endtask

    task automatic test_fill();
        logic rv, ok, fe; logic [5:0] pg; bit e_ok, e_err; logic [5:0] e_pg;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            wait_ready("fill");
            alloc_op(1'b0, 6'd0, rv, ok, pg, fe);
            model_step(1'b1, 1'b0, 6'd0, e_ok, e_pg, e_err);
            checks++;
            if ({rv, ok, pg} !== {1'b1, 1'b1, 6'(i)}) begin
                errors++; $display("FAIL fill_alloc %0d: rv=%b ok=%b page=%0d want 1/1/%0d", i, rv, ok, pg, i);
            end
        end
        checks++;
        if (o_full !== 1'b1 || o_data !== '1 || o_cnt !== 7'd0) begin
            errors++; $display("FAIL fill_full: full=%b data=%h count=%0d want 1/all-ones/0", o_full, o_data, o_cnt);
        end
        wait_ready("fill_over");
        alloc_op(1'b0, 6'd0, rv, ok, pg, fe);
        checks++;
        if ({rv, ok, pg} !== {1'b1, 1'b0, 6'd0}) begin
            errors++; $display("FAIL alloc_when_full: rv=%b ok=%b page=%0d want 1/0/0", rv, ok, pg);
        end
        checks++;
        if (o_data !== '1 || o_ready !== 1'b1) begin
            errors++; $display("FAIL full_unchanged: data=%h ready=%b want all-ones/1", o_data, o_ready);
        end
    endtask

    task automatic test_free_from_full();
        logic rv, ok, fe; logic [5:0] pg; bit e_ok, e_err; logic [5:0] e_pg;
        free_valid = 1'b1; free_page = 6'd5;
        tick();
        free_valid = 1'b0;
        model_step(1'b0, 1'b1, 6'd5, e_ok, e_pg, e_err);
        checks++;
        if (o_fe !== 1'b0 || o_data !== 64'hFFFF_FFFF_FFFF_FFDF || o_cnt !== 7'd1 || o_full !== 1'b0) begin
            errors++; $display("FAIL free5: err=%b data=%h count=%0d full=%b want 0/FFFFFFFFFFFFFFDF/1/0", o_fe, o_data, o_cnt, o_full);
        end
        wait_ready("refill");
        alloc_op(1'b0, 6'd0, rv, ok, pg, fe);
        model_step(1'b1, 1'b0, 6'd0, e_ok, e_pg, e_err);
        checks++;
        if ({rv, ok, pg} !== {1'b1, 1'b1, 6'd5} || o_full !== 1'b1) begin
            errors++; $display("FAIL refill: rv=%b ok=%b page=%0d full=%b want 1/1/5/1", rv, ok, pg, o_full);
        end
    endtask

    task automatic test_double_free();
        do_reset();
        wait_ready("dfree");
        free_valid = 1'b1; free_page = 6'd9;
        tick();
        free_valid = 1'b0;
        checks++;
        if (o_fe !== 1'b1 || o_cnt !== 7'd64 || o_data !== '0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL double_free: err=%b count=%0d data=%h ready=%b want 1/64/0/1", o_fe, o_cnt, o_data, o_ready);
        end
        tick();
        checks++;
        if (o_fe !== 1'b0 || o_ready !== 1'b1) begin
            errors++; $display("FAIL double_free_pulse: err=%b ready=%b want 0/1", o_fe, o_ready);
        end
    endtask

    task automatic test_simultaneous();
        logic rv, ok, fe; logic [5:0] pg; bit e_ok, e_err; logic [5:0] e_pg;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_ready("simul_setup");
            alloc_op(1'b0, 6'd0, rv, ok, pg, fe);
            model_step(1'b1, 1'b0, 6'd0, e_ok, e_pg, e_err);
        end
        wait_ready("simul");
        alloc_op(1'b1, 6'd2, rv, ok, pg, fe);
        model_step(1'b1, 1'b1, 6'd2, e_ok, e_pg, e_err);
        checks++;
        if ({rv, ok, pg, fe} !== {1'b1, 1'b1, 6'd4, 1'b0}) begin
            errors++; $display("FAIL simul_resp: rv=%b ok=%b page=%0d err=%b want 1/1/4/0", rv, ok, pg, fe);
        end
        checks++;
        if (o_data !== 64'h1B || o_cnt !== 7'd60) begin
            errors++; $display("FAIL simul_state: data=%h count=%0d want 1b/60", o_data, o_cnt);
        end
        wait_ready("simul_same");
        alloc_op(1'b1, 6'd2, rv, ok, pg, fe);
        model_step(1'b1, 1'b1, 6'd2, e_ok, e_pg, e_err);
        checks++;
        if ({rv, ok, pg, fe} !== {1'b1, 1'b1, 6'd2, 1'b1} || o_data !== 64'h1F || o_cnt !== 7'd59) begin
            errors++; $display("FAIL simul_same_page: ok=%b page=%0d err=%b data=%h count=%0d want 1/2/1/1f/59", ok, pg, fe, o_data, o_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wait_ready("rmid");
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        rst = 1'b1; free_valid = 1'b1; free_page = 6'd10;
        tick();
        free_valid = 1'b0;
        checks++;
        if (o_rv !== 1'b0 || o_fe !== 1'b0 || o_data !== '0 || o_cnt !== 7'd64 || o_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_settle: rv=%b err=%b data=%h count=%0d ready=%b want 0/0/0/64/0", o_rv, o_fe, o_data, o_cnt, o_ready);
        end
        do_reset();
        wait_ready("rmid2");
        alloc_valid = 1'b1; rst = 1'b1;
        tick();
        alloc_valid = 1'b0;
        checks++;
        if (o_rv !== 1'b0 || o_data !== '0 || o_cnt !== 7'd64) begin
            errors++; $display("FAIL reset_drops_resp: rv=%b data=%h count=%0d want 0/0/64", o_rv, o_data, o_cnt);
        end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) used[i] = 1'b0;
        for (int k = 0; k < lat; k++) begin
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL rmid_settle c%0d: alloc_ready=%b want 0", k, o_ready); end
            tick();
        end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: alloc_ready=%b want 1", o_ready); end
    endtask

    task automatic test_random();
        logic rv, ok, fe; logic [5:0] pg; bit e_ok, e_err; logic [5:0] e_pg;
        int r; logic [5:0] fp;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            r  = $urandom_range(0, 9);
            fp = 6'($urandom_range(0, 63));
            if (r < 6) begin
                wait_ready("rand");
                alloc_op(r < 2, fp, rv, ok, pg, fe);
                model_step(1'b1, r < 2, fp, e_ok, e_pg, e_err);
                checks++;
                if ({rv, ok, pg, fe} !== {1'b1, e_ok, e_pg, e_err}) begin
                    errors++; $display("FAIL rand_alloc %0d: rv=%b ok=%b page=%0d err=%b want 1/%b/%0d/%b", it, rv, ok, pg, fe, e_ok, e_pg, e_err);
                end
            end else begin
                free_valid = 1'b1; free_page = fp;
                tick();
                free_valid = 1'b0;
                model_step(1'b0, 1'b1, fp, e_ok, e_pg, e_err);
                checks++;
                if (o_fe !== e_err || o_rv !== 1'b0) begin
                    errors++; $display("FAIL rand_free %0d: err=%b rv=%b want %b/0", it, o_fe, o_rv, e_err);
                end
            end
            checks++;
            if (o_data !== model_bits() || o_cnt !== 7'(model_free_cnt()) || o_full !== (model_free_cnt() == 0)) begin
                errors++; $display("FAIL rand_state %0d: data=%h count=%0d full=%b want %h/%0d", it, o_data, o_cnt, o_full, model_bits(), model_free_cnt());
            end
        end
    endtask

    initial begin
        for (int rr = 0; rr < 2; rr++) begin
            run = rr;
            lat = rr + 1;
            test_reset();
            test_fill();
            test_free_from_full();
            test_double_free();
            test_simultaneous();
            test_reset_mid();
            test_random();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
